// File: rtl/conv_requant_relu_pkg.sv
// Shared types and constants for the convolution requantisation stage.
package conv_requant_relu_pkg;

    localparam int ACC_W_DEF = 32;

    typedef logic signed [7:0]           pixel_t;
    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    localparam pixel_t PIX_MAX = 8'sd127;
    localparam pixel_t PIX_MIN = 8'sd0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/conv_requant_relu_pipe.sv
// Three-stage bias / multiply / round-shift-ReLU-saturate datapath.
// Config travels with each pixel so a pixel never sees a mid-flight config change.
module requant_pipe
    import conv_requant_relu_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic signed [MULT_W-1:0] mult,
    input  logic [SHIFT_W-1:0]       shift,
    output logic                     prod_valid,
    output logic                     valid_out,
    output pixel_t                   pixel_out
);

    localparam int SUM_W  = ACC_W + 1;
    localparam int PROD_W = ACC_W + MULT_W + 1;
    localparam int RND_W  = PROD_W + 1;

    logic                     v1_r;
    logic                     v2_r;
    logic signed [SUM_W-1:0]  sum_r;
    logic signed [MULT_W-1:0] mult_r;
    logic [SHIFT_W-1:0]       shift1_r;
    logic [SHIFT_W-1:0]       shift2_r;
    logic signed [PROD_W-1:0] prod_r;
    logic [RND_W-1:0]         rnd_s;
    logic signed [RND_W-1:0]  shifted_s;
    pixel_t                   clip_s;

    assign prod_valid = v2_r;

    // Round-half-up shift, then ReLU and int8 saturation; rnd_s is zero when shift is zero.
    always_comb begin
        rnd_s     = {{(RND_W-1){1'b0}}, 1'b1} << shift2_r;
        rnd_s     = rnd_s >> 1;
        shifted_s = ($signed({prod_r[PROD_W-1], prod_r}) + $signed(rnd_s)) >>> shift2_r;
        if (shifted_s[RND_W-1]) begin
            clip_s = PIX_MIN;
        end else if (|shifted_s[RND_W-2:7]) begin
            clip_s = PIX_MAX;
        end else begin
            clip_s = $signed(shifted_s[7:0]);
        end
    end

    // Stage registers; data only moves with its valid so pixel_out holds across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            valid_out <= 1'b0;
            sum_r     <= '0;
            mult_r    <= '0;
            shift1_r  <= '0;
            shift2_r  <= '0;
            prod_r    <= '0;
            pixel_out <= PIX_MIN;
        end else begin
            v1_r      <= valid_in;
            v2_r      <= v1_r;
            valid_out <= v2_r;
            if (valid_in) begin
                sum_r    <= {acc_in[ACC_W-1], acc_in} + {bias[ACC_W-1], bias};
                mult_r   <= mult;
                shift1_r <= shift;
            end
            if (v1_r) begin
                prod_r   <= $signed({{(PROD_W-SUM_W){sum_r[SUM_W-1]}}, sum_r})
                          * $signed({{(PROD_W-MULT_W){mult_r[MULT_W-1]}}, mult_r});
                shift2_r <= shift1_r;
            end
            if (v2_r) begin
                pixel_out <= clip_s;
            end
        end
    end

endmodule

// File: rtl/conv_requant_relu.sv
// Per-channel requantise + ReLU stage: config registers, frame FSM and
// frame_done / cfg_err generation around the requant_pipe datapath.
module conv_requant_relu
    import conv_requant_relu_pkg::*;
#(
    parameter int MAP_WIDTH = 28,
    parameter int ACC_W     = 32,
    parameter int MULT_W    = 16,
    parameter int SHIFT_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic signed [ACC_W-1:0]  cfg_bias,
    input  logic signed [MULT_W-1:0] cfg_mult,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    output logic                     cfg_err,
    input  logic                     valid_in,
    input  logic signed [ACC_W-1:0]  acc_in,
    output logic                     valid_out,
    output pixel_t                   pixel_out,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int FRAME = MAP_WIDTH * MAP_WIDTH;
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic signed [ACC_W-1:0]  bias_r;
    logic signed [MULT_W-1:0] mult_r;
    logic [SHIFT_W-1:0]       shift_r;
    logic [1:0]               state_r;
    logic [1:0]               state_nxt_s;
    logic [CNT_W-1:0]         in_count_r;
    logic [CNT_W-1:0]         in_count_nxt_s;
    logic [CNT_W-1:0]         out_count_r;
    logic                     busy_r;
    logic                     frame_done_r;
    logic                     cfg_err_r;
    logic                     prod_valid_s;

    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign cfg_err    = cfg_err_r;

    requant_pipe #(
        .ACC_W   (ACC_W),
        .MULT_W  (MULT_W),
        .SHIFT_W (SHIFT_W)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .acc_in     (acc_in),
        .bias       (bias_r),
        .mult       (mult_r),
        .shift      (shift_r),
        .prod_valid (prod_valid_s),
        .valid_out  (valid_out),
        .pixel_out  (pixel_out)
    );

    // Frame FSM: DRAIN waits for the last pixel while counting next-frame inputs.
    always_comb begin
        state_nxt_s    = state_r;
        in_count_nxt_s = in_count_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_in) begin
                    state_nxt_s    = ST_RUN;
                    in_count_nxt_s = CNT_ONE;
                end else begin
                    in_count_nxt_s = in_count_r;
                end
            end
            ST_RUN: begin
                if (valid_in && (in_count_r == FRAME_LAST)) begin
                    state_nxt_s    = ST_DRAIN;
                    in_count_nxt_s = '0;
                end else if (valid_in) begin
                    in_count_nxt_s = in_count_r + CNT_ONE;
                end else begin
                    in_count_nxt_s = in_count_r;
                end
            end
            ST_DRAIN: begin
                if (valid_in) begin
                    in_count_nxt_s = in_count_r + CNT_ONE;
                end else begin
                    in_count_nxt_s = in_count_r;
                end
                if (frame_done_r) begin
                    state_nxt_s = (in_count_nxt_s != '0) ? ST_RUN : ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                in_count_nxt_s = '0;
            end
        endcase
    end

    // State, counters, config and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            in_count_r   <= '0;
            out_count_r  <= '0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            cfg_err_r    <= 1'b0;
            bias_r       <= '0;
            mult_r       <= {{(MULT_W-1){1'b0}}, 1'b1};
            shift_r      <= '0;
        end else begin
            state_r    <= state_nxt_s;
            in_count_r <= in_count_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            cfg_err_r  <= cfg_we && (state_r != ST_IDLE);
            if (cfg_we && (state_r == ST_IDLE)) begin
                bias_r  <= cfg_bias;
                mult_r  <= cfg_mult;
                shift_r <= cfg_shift;
            end
            // Pixel in the product stage reaches valid_out next cycle, so frame_done lines up with it.
            if (prod_valid_s && (out_count_r == FRAME_LAST)) begin
                out_count_r  <= '0;
                frame_done_r <= 1'b1;
            end else if (prod_valid_s) begin
                out_count_r  <= out_count_r + CNT_ONE;
                frame_done_r <= 1'b0;
            end else begin
                frame_done_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_requant_relu.sv
// Randomised self-checking bench for conv_requant_relu with a timestamped reference queue.
module tb_conv_requant_relu;

    localparam int MW = 4;
    localparam int N  = MW * MW;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_we = 1'b0;
    logic signed [31:0] cfg_bias = '0;
    logic signed [15:0] cfg_mult = '0;
    logic [4:0]         cfg_shift = '0;
    logic               cfg_err;
    logic               valid_in = 1'b0;
    logic signed [31:0] acc_in = '0;
    logic               valid_out;
    logic signed [7:0]  pixel_out;
    logic               busy;
    logic               frame_done;

    conv_requant_relu #(.MAP_WIDTH(MW), .ACC_W(32), .MULT_W(16), .SHIFT_W(5)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_bias(cfg_bias), .cfg_mult(cfg_mult),
        .cfg_shift(cfg_shift), .cfg_err(cfg_err), .valid_in(valid_in), .acc_in(acc_in),
        .valid_out(valid_out), .pixel_out(pixel_out), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     due;
        longint pix;
        bit     last;
    } exp_t;

    exp_t   expq[$];
    int     checks = 0;
    int     errors = 0;
    int     iter = 0;
    int     acc_cnt = 0;
    int     done_cnt = 0;
    bit     err_pend = 1'b0;
    longint last_pix = 0;
    longint m_bias = 0;
    longint m_mult = 1;
    int     m_shift = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint ref_px(input longint a);
        longint r;
        r = (a + m_bias) * m_mult;
        if (m_shift != 0) r = (r + (longint'(1) <<< (m_shift - 1))) >>> m_shift;
        if (r < 0) return 0;
        if (r > 127) return 127;
        return r;
    endfunction

    function automatic logic signed [31:0] rand_acc();
        int tmp;
        if ($urandom_range(0, 3) == 0) begin
            tmp = int'($urandom);
        end else begin
            tmp = int'($urandom_range(0, 600)) - 300;
        end
        return tmp;
    endfunction

    // One clock: check outputs against the model, then drive this cycle's inputs.
    task automatic step(input bit v, input logic signed [31:0] a, input bit we,
                        input logic signed [31:0] b, input logic signed [15:0] m, input logic [4:0] s);
        bit     idle;
        bit     ev;
        bit     efd;
        longint epix;
        exp_t   ent;
        @(negedge clk);
        idle = (acc_cnt == done_cnt);
        ev   = 1'b0;
        efd  = 1'b0;
        epix = last_pix;
        if (expq.size() != 0 && expq[0].due == iter) begin
            ent      = expq.pop_front();
            ev       = 1'b1;
            epix     = ent.pix;
            efd      = ent.last;
            last_pix = ent.pix;
        end
        check("valid_out", valid_out, ev);
        check("pixel_out", pixel_out, epix);
        check("frame_done", frame_done, efd);
        check("busy", busy, !idle);
        check("cfg_err", cfg_err, err_pend);
        if (efd) done_cnt += N;
        err_pend  = we && !idle;
        valid_in  = v;
        acc_in    = a;
        cfg_we    = we;
        cfg_bias  = b;
        cfg_mult  = m;
        cfg_shift = s;
        if (v) begin
            expq.push_back('{due: iter + 3, pix: ref_px(longint'(a)), last: ((acc_cnt % N) == N - 1)});
            acc_cnt++;
        end
        if (we && idle) begin
            m_bias  = longint'(b);
            m_mult  = longint'(m);
            m_shift = int'(s);
        end
        iter++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'sd0, 1'b0, 32'sd0, 16'sd0, 5'd0);
    endtask

    task automatic feed(input logic signed [31:0] a, input int max_gap);
        step(1'b1, a, 1'b0, 32'sd0, 16'sd0, 5'd0);
        if (max_gap > 0) idle_cycles(int'($urandom_range(1, max_gap)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        cfg_we   = 1'b0;
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_pixel_out", pixel_out, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        expq.delete();
        acc_cnt  = 0;
        done_cnt = 0;
        err_pend = 1'b0;
        last_pix = 0;
        m_bias   = 0;
        m_mult   = 1;
        m_shift  = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        do_reset();
        idle_cycles(2);

        // Default config: identity + ReLU + saturation.
        feed(-32'sd5, 0);
        feed(32'sd0, 0);
        feed(32'sd42, 0);
        feed(32'sd300, 0);
        for (int i = 0; i < N - 4; i++) feed(rand_acc(), 0);
        idle_cycles(6);

        // bias=10 mult=3 shift=2.
        step(1'b0, 32'sd0, 1'b1, 32'sd10, 16'sd3, 5'd2);
        feed(32'sd5, 0);
        feed(-32'sd4, 0);
        feed(-32'sd20, 0);
        for (int i = 0; i < N - 3; i++) feed(rand_acc(), 1);
        idle_cycles(6);

        // Round-half-up with shift=1.
        step(1'b0, 32'sd0, 1'b1, 32'sd0, 16'sd1, 5'd1);
        feed(32'sd3, 0);
        feed(32'sd1, 0);
        feed(-32'sd1, 0);
        for (int i = 0; i < N - 3; i++) feed(rand_acc(), 0);
        idle_cycles(6);

        // Config written together with the first pixel (that pixel keeps the old config), 1-3 cycle gaps.
        step(1'b1, rand_acc(), 1'b1, 32'(int'($urandom_range(0, 200)) - 100),
             16'($urandom_range(1, 40)), 5'($urandom_range(0, 6)));
        idle_cycles(int'($urandom_range(1, 3)));
        for (int i = 0; i < N - 1; i++) feed(rand_acc(), 3);
        idle_cycles(6);

        // Fully random config, two back-to-back frames, rejected write mid-frame.
        step(1'b0, 32'sd0, 1'b1, 32'($urandom), 16'($urandom), 5'($urandom_range(0, 31)));
        for (int i = 0; i < 2 * N; i++) begin
            if (i == 5) step(1'b1, rand_acc(), 1'b1, 32'sd7, 16'sd2, 5'd1);
            else        step(1'b1, rand_acc(), 1'b0, 32'sd0, 16'sd0, 5'd0);
        end
        idle_cycles(6);

        // Reset after 7 inputs, then a fresh frame.
        step(1'b0, 32'sd0, 1'b1, 32'sd3, 16'sd5, 5'd1);
        for (int i = 0; i < 7; i++) feed(rand_acc(), 0);
        do_reset();
        idle_cycles(2);
        for (int i = 0; i < N; i++) feed(rand_acc(), 2);
        idle_cycles(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
